// File: rtl/ising_run_ctrl_if.sv
// Control bus between the AXI register block and the Ising run sequencer.
//   master (software side): start, abort, run_cycles, wr_req -> ; <- wr_grant, busy, done,
//                           spins, spins_valid
//   slave  (sequencer)    : the mirror image of master
interface ising_run_ctrl_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 32
) ();

  logic             start;
  logic             abort;
  logic [CNT_W-1:0] run_cycles;
  logic             wr_req;
  logic             wr_grant;
  logic             busy;
  logic             done;
  logic [N-1:0]     spins;
  logic             spins_valid;

  modport master (
    output start, abort, run_cycles, wr_req,
    input  wr_grant, busy, done, spins, spins_valid
  );

  modport slave (
    input  start, abort, run_cycles, wr_req,
    output wr_grant, busy, done, spins, spins_valid
  );

endinterface

// File: rtl/ising_run_ctrl.sv
// Run sequencer for the coupled-oscillator Ising array.
// Holds the oscillators in reset, releases them for a programmed number of cycles, then
// majority-votes each spin's phase against the reference oscillator and reports the result.
// Weight writes are only granted while idle.
// Ports:
//   clk, rst    : single clock, synchronous active-high reset
//   bus         : control bus (start/abort/run_cycles/wr_req in; wr_grant/busy/done/spins out)
//   phase_in    : asynchronous per-spin oscillator phases
//   ref_in      : asynchronous reference oscillator phase
//   ising_rstn  : registered oscillator reset to the array (low = held)
module ising_run_ctrl #(
  parameter int unsigned N           = 8,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned NUM_SAMPLES = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  ising_run_ctrl_if.slave bus,
  input  logic [N-1:0]    phase_in,
  input  logic            ref_in,
  output logic            ising_rstn
);

  localparam int unsigned SW = $clog2(NUM_SAMPLES + 1);
  localparam logic [SW:0] NsCmp = NUM_SAMPLES[SW:0];

  typedef enum logic [2:0] {StIdle, StHold, StRun, StSample, StDone} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       len_q, len_d;    // run length latched at start
  logic [CNT_W-1:0]       tmr_q, tmr_d;    // shared down-counter for HOLD/RUN/SAMPLE
  logic [N-1:0][SW-1:0]   cnt_q, cnt_d;    // per-spin mismatch counts
  logic [N-1:0]           spins_q, spins_d;
  logic                   valid_q, valid_d;
  logic                   rstn_q, rstn_d;

  logic [SYNC_STAGES-1:0][N:0] sync_q;
  logic [N-1:0]                phase_sync;
  logic                        ref_sync;

  // Free-running synchronizers; reference shares the same depth so lags match.
  always_ff @(posedge clk) begin
    sync_q[0] <= {ref_in, phase_in};
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_q[s] <= sync_q[s-1];
    end
  end

  assign {ref_sync, phase_sync} = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    spins_d = spins_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          state_d = StHold;
          len_d   = bus.run_cycles;
          tmr_d   = CNT_W'(RST_CYCLES);
          valid_d = 1'b0;
        end
      end
      StHold: begin
        if (tmr_q == CNT_W'(1)) begin
          if (len_q == '0) begin
            state_d = StSample;
            tmr_d   = CNT_W'(NUM_SAMPLES);
            cnt_d   = '0;
          end else begin
            state_d = StRun;
            tmr_d   = len_q;
          end
        end else begin
          tmr_d = tmr_q - CNT_W'(1);
        end
      end
      StRun: begin
        if (tmr_q == CNT_W'(1)) begin
          state_d = StSample;
          tmr_d   = CNT_W'(NUM_SAMPLES);
          cnt_d   = '0;
        end else begin
          tmr_d = tmr_q - CNT_W'(1);
        end
      end
      StSample: begin
        for (int i = 0; i < N; i++) begin
          if (phase_sync[i] ^ ref_sync) cnt_d[i] = cnt_q[i] + SW'(1);
        end
        if (tmr_q == CNT_W'(1)) begin
          // Resolve from cnt_d so the final sample is included; lands with the DONE entry.
          state_d = StDone;
          tmr_d   = '0;
          valid_d = 1'b1;
          for (int i = 0; i < N; i++) begin
            spins_d[i] = {cnt_d[i], 1'b0} > NsCmp;
          end
        end else begin
          tmr_d = tmr_q - CNT_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (bus.abort && (state_q != StIdle)) begin
      state_d = StIdle;
      tmr_d   = '0;
      spins_d = spins_q;
      valid_d = valid_q;
    end
  end

  // Oscillators run only while the next state is RUN or SAMPLE; registered to avoid glitches.
  assign rstn_d = (state_d == StRun) || (state_d == StSample);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      tmr_q   <= '0;
      cnt_q   <= '0;
      spins_q <= '0;
      valid_q <= 1'b0;
      rstn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      spins_q <= spins_d;
      valid_q <= valid_d;
      rstn_q  <= rstn_d;
    end
  end

  assign ising_rstn      = rstn_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StDone);
  assign bus.spins       = spins_q;
  assign bus.spins_valid = valid_q;
  // Never grant in the cycle a run is accepted.
  assign bus.wr_grant    = bus.wr_req && (state_q == StIdle) && !bus.start;

endmodule
